bcd_addsub_seq: RTL and testbench
=================================

BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

Interface
REQ-001 SHALL have parameter NumDigits, default 8, number of BCD significand digits (>=2).
REQ-002 SHALL have parameter ExpWidth, default $clog2(NumDigits)+1, exponent width in bits.
REQ-003 SHALL define W = 2+4*NumDigits+ExpWidth, the operand width. Layout from MSB: error, sign, digit NumDigits-1 ... digit 0 (4 bits each), exponent.
REQ-004 SHALL encode value = (-1)^sign × significand × 10^exponent.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port in_valid_i, input, 1 bit: operands and op are valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit: block accepts operands.
REQ-009 SHALL have port op_i, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-010 SHALL have ports a_i and b_i, input, W bits each: the operands.
REQ-011 SHALL have port out_valid_o, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready_i, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port y_o, output, W bits: the result, registered.

Function
REQ-014 SHALL implement FSM states IDLE, ALIGN, ADD, FIX, NORM, DONE.
REQ-015 in_ready_o SHALL be 1 only in IDLE. The handshake occurs when in_valid_i && in_ready_o; on it the block captures a_i, b_i and op_i.
REQ-016 On handshake, if either operand has error=1 or any digit >9, the block SHALL go directly to DONE with the error result: error=1, sign=0, significand=0, exponent=0.
REQ-017 Otherwise the block SHALL go to ALIGN. Effective sign of b = b.sign XOR op_i.
REQ-018 In each ALIGN cycle, if the exponents differ, the operand with the smaller exponent SHALL shift right one digit (truncate, insert 0 at MSD) and increment its exponent.
REQ-019 In the ALIGN cycle where the exponents are equal, the block SHALL go to ADD. On that edge, for opposite effective signs with |b|>|a|, the operands SHALL be swapped so the larger magnitude is the minuend.
REQ-020 ADD SHALL process one digit per cycle, LSD first, for exactly NumDigits cycles.
REQ-021 In ADD, for same effective signs: sum = a+b+carry, with a decimal adjust when sum>9. For opposite signs: diff = a-b-borrow, +10 with borrow when negative.
REQ-022 Result sign SHALL be a.sign for same signs, otherwise the sign of the larger magnitude. An exact-zero result SHALL have sign 0.
REQ-023 FIX takes 1 cycle. On a final carry it SHALL shift the significand right, insert 1 at MSD, and increment the exponent. If the exponent is already 2^ExpWidth-1, the result SHALL become the error result.
REQ-024 In each NORM cycle, if exponent≠0 and MSD=0, the block SHALL shift the significand left (0 into LSD) and decrement the exponent. Otherwise it SHALL go to DONE.
REQ-025 Latency from the handshake edge to out_valid_o=1 SHALL be d+NumDigits+k+4 cycles, where d = |exp_a−exp_b| and k = NORM shifts. The REQ-016 path SHALL take 1 cycle.
REQ-026 In DONE, out_valid_o SHALL be 1 and y_o SHALL be stable until out_ready_i=1. On that edge the block SHALL return to IDLE, with out_valid_o=0 the next cycle.
REQ-027 in_valid_i, a_i and b_i SHALL be ignored outside IDLE. Captured operands SHALL be unaffected by input changes mid-operation.
REQ-028 No back-to-back overlap: a new handshake is possible no earlier than the cycle after the DONE handshake.

Reset
REQ-029 rst_ni=0 at a rising edge in any state SHALL force IDLE and clear all datapath registers and y_o to 0, with out_valid_o=0. Any operation in flight is aborted and produces no result.
REQ-030 in_ready_o SHALL be 1 from the first cycle after reset with rst_ni=1.

Verification (NumDigits=4, ExpWidth=3)
REQ-031 SHALL cover add: a=+1234e0, b=+0005e0, op=0 -> y=+1239e0, out_valid_o exactly 8 cycles after the handshake.
REQ-032 SHALL cover carry: +9999e0 + +0001e0 -> +1000e1, error=0. Also +9999e7 + +0001e7 -> error result (error=1, all other fields 0).
REQ-033 SHALL cover subtract with swap: +0012e0 − +0345e0 -> −0333e0. Also +0345e0 − +0345e0 -> +0000e0, sign=0.
REQ-034 SHALL cover align and normalize: +0500e1 + +0025e0 -> +5020e0, latency 10 cycles (d=1, k=1).
REQ-035 SHALL cover input error: a.error=1 -> error result 1 cycle after the handshake. Also digit 0xA in b -> same result.
REQ-036 SHALL cover backpressure and reset: hold out_ready_i=0 for 5 cycles -> y_o stable, out_valid_o=1. Then rst_ni=0 mid-ADD -> IDLE, out_valid_o=0, in_ready_o=1 the cycle after rst_ni returns to 1.

Source files
------------

// File: rtl/bcd_addsub_seq.sv
// Sequential BCD floating-point adder/subtractor.
// Operands are {error, sign, NumDigits BCD digits, exponent}; the significands
// are aligned one digit per cycle, combined one digit per cycle (LSD first),
// then carry-fixed and normalised before the registered result is offered.
module bcd_addsub_seq #(
    parameter int NumDigits = 8,
    parameter int ExpWidth  = $clog2(NumDigits) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic                                 op_i,
    input  logic [2+4*NumDigits+ExpWidth-1:0]    a_i,
    input  logic [2+4*NumDigits+ExpWidth-1:0]    b_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [2+4*NumDigits+ExpWidth-1:0]    y_o
);

    localparam int W    = 2 + 4 * NumDigits + ExpWidth;
    localparam int SigW = 4 * NumDigits;
    localparam int CntW = $clog2(NumDigits);
    localparam logic [CntW-1:0]     LastCnt = CntW'(NumDigits - 1);
    localparam logic [ExpWidth-1:0] ExpMax  = '1;
    localparam logic [ExpWidth-1:0] ExpOne  = ExpWidth'(1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        FIX,
        NORM,
        DONE
    } state_t;

    state_t              state;
    logic [SigW-1:0]     sig_a;
    logic [SigW-1:0]     sig_b;
    logic [SigW-1:0]     res;
    logic [ExpWidth-1:0] exp_a;
    logic [ExpWidth-1:0] exp_b;
    logic                sign_a;
    logic                sign_b;
    logic                carry;
    logic                res_err;
    logic [CntW-1:0]     cnt;

    logic                a_err;
    logic                b_err;
    logic                a_sign;
    logic                b_sign;
    logic [SigW-1:0]     a_sig;
    logic [SigW-1:0]     b_sig;
    logic [ExpWidth-1:0] a_exp;
    logic [ExpWidth-1:0] b_exp;
    logic                in_bad;

    logic [4:0]          dig_sum;
    logic [3:0]          dig_out;
    logic                dig_carry;

    // True when any nibble of a significand is not a legal BCD digit.
    function automatic logic bad_digits(input logic [SigW-1:0] s);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NumDigits; i++) begin
            if (s[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign a_err  = a_i[W-1];
    assign b_err  = b_i[W-1];
    assign a_sign = a_i[W-2];
    assign b_sign = b_i[W-2];
    assign a_sig  = a_i[W-3 -: SigW];
    assign b_sig  = b_i[W-3 -: SigW];
    assign a_exp  = a_i[ExpWidth-1:0];
    assign b_exp  = b_i[ExpWidth-1:0];
    assign in_bad = a_err | b_err | bad_digits(a_sig) | bad_digits(b_sig);

    assign in_ready_o = (state == IDLE);

    // One BCD digit step on the current LSDs: decimal add with carry, or
    // decimal subtract with borrow (a is always the larger magnitude here).
    always_comb begin
        dig_sum   = 5'd0;
        dig_out   = 4'd0;
        dig_carry = 1'b0;
        if (sign_a == sign_b) begin
            dig_sum = {1'b0, sig_a[3:0]} + {1'b0, sig_b[3:0]} + {4'd0, carry};
            if (dig_sum > 5'd9) begin
                dig_out   = 4'(dig_sum - 5'd10);
                dig_carry = 1'b1;
            end else begin
                dig_out = dig_sum[3:0];
            end
        end else begin
            dig_sum = {1'b0, sig_a[3:0]} - {1'b0, sig_b[3:0]} - {4'd0, carry};
            if (dig_sum[4]) begin
                dig_out   = 4'(dig_sum + 5'd10);
                dig_carry = 1'b1;
            end else begin
                dig_out = dig_sum[3:0];
            end
        end
    end

    // Control FSM and datapath: capture, align, digit-serial add, fix, normalise, hold.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            sig_a       <= '0;
            sig_b       <= '0;
            res         <= '0;
            exp_a       <= '0;
            exp_b       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            carry       <= 1'b0;
            res_err     <= 1'b0;
            cnt         <= '0;
            y_o         <= '0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        if (in_bad) begin
                            y_o         <= {1'b1, {(W-1){1'b0}}};
                            out_valid_o <= 1'b1;
                            state       <= DONE;
                        end else begin
                            sig_a   <= a_sig;
                            sig_b   <= b_sig;
                            exp_a   <= a_exp;
                            exp_b   <= b_exp;
                            sign_a  <= a_sign;
                            sign_b  <= b_sign ^ op_i;
                            res_err <= 1'b0;
                            state   <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (exp_a < exp_b) begin
                        sig_a <= sig_a >> 4;
                        exp_a <= exp_a + ExpOne;
                    end else if (exp_b < exp_a) begin
                        sig_b <= sig_b >> 4;
                        exp_b <= exp_b + ExpOne;
                    end else begin
                        if ((sign_a != sign_b) && (sig_b > sig_a)) begin
                            sig_a  <= sig_b;
                            sig_b  <= sig_a;
                            sign_a <= sign_b;
                            sign_b <= sign_a;
                        end
                        cnt   <= '0;
                        carry <= 1'b0;
                        res   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    res   <= {dig_out, res[SigW-1:4]};
                    sig_a <= sig_a >> 4;
                    sig_b <= sig_b >> 4;
                    carry <= dig_carry;
                    cnt   <= cnt + CntW'(1);
                    if (cnt == LastCnt) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (carry) begin
                        if (exp_a == ExpMax) begin
                            res_err <= 1'b1;
                            res     <= '0;
                            exp_a   <= '0;
                        end else begin
                            res   <= {4'd1, res[SigW-1:4]};
                            exp_a <= exp_a + ExpOne;
                        end
                    end
                    carry <= 1'b0;
                    state <= NORM;
                end
                NORM: begin
                    if ((exp_a != '0) && (res[SigW-1 -: 4] == 4'd0)) begin
                        res   <= res << 4;
                        exp_a <= exp_a - ExpOne;
                    end else begin
                        y_o         <= {res_err, ((res != '0) ? sign_a : 1'b0), res, exp_a};
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Testbench for bcd_addsub_seq (4 digits, 3-bit exponent) with a decimal
// arithmetic reference model.
module tb_bcd_addsub_seq;

    localparam int N         = 4;
    localparam int EW        = 3;
    localparam int W         = 2 + 4 * N + EW;
    localparam int Pow10N    = 10000;
    localparam int MinNorm   = 1000;
    localparam int ExpMaxVal = 7;
    localparam int MaxWait   = 200;

    logic         clk_i       = 1'b0;
    logic         rst_ni      = 1'b0;
    logic         in_valid_i  = 1'b0;
    logic         op_i        = 1'b0;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] a_i         = '0;
    logic [W-1:0] b_i         = '0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] y_o;

    int checks = 0;
    int errors = 0;

    bcd_addsub_seq #(
        .NumDigits(N),
        .ExpWidth (EW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .y_o        (y_o)
    );

    always #5 clk_i = ~clk_i;

    // Build an operand word from a decimal magnitude.
    function automatic logic [W-1:0] pack(input logic err, input logic sign, input int mag, input int e);
        logic [4*N-1:0] s;
        int m;
        m = mag;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {err, sign, s, EW'(e)};
    endfunction

    // Decimal reference: expected result word and handshake-to-valid latency.
    function automatic void ref_model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] y, output int lat);
        int ma, mb, ea, eb, m, e, d, k;
        logic sa, sb, sr;
        bit bad;
        bad = (a[W-1] == 1'b1) || (b[W-1] == 1'b1);
        ma = 0;
        mb = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (a[EW+4*i +: 4] > 4'd9 || b[EW+4*i +: 4] > 4'd9) bad = 1'b1;
            ma = ma * 10 + int'(a[EW+4*i +: 4]);
            mb = mb * 10 + int'(b[EW+4*i +: 4]);
        end
        if (bad) begin
            y   = pack(1'b1, 1'b0, 0, 0);
            lat = 1;
            return;
        end
        ea = int'(a[EW-1:0]);
        eb = int'(b[EW-1:0]);
        sa = a[W-2];
        sb = b[W-2] ^ op;
        d  = (ea > eb) ? ea - eb : eb - ea;
        while (ea < eb) begin ma = ma / 10; ea++; end
        while (eb < ea) begin mb = mb / 10; eb++; end
        e = ea;
        if (sa == sb) begin
            m = ma + mb; sr = sa;
        end else if (ma >= mb) begin
            m = ma - mb; sr = sa;
        end else begin
            m = mb - ma; sr = sb;
        end
        if (m >= Pow10N) begin
            if (e == ExpMaxVal) begin
                y   = pack(1'b1, 1'b0, 0, 0);
                lat = d + N + 4;
                return;
            end
            m = m / 10;
            e++;
        end
        k = 0;
        while (e != 0 && m < MinNorm) begin
            m = m * 10; e--; k++;
        end
        if (m == 0) sr = 1'b0;
        y   = pack(1'b0, sr, m, e);
        lat = d + N + k + 4;
    endfunction

    // Random legal operand with a random number of significant digits.
    function automatic logic [W-1:0] rand_operand();
        int nd, mag;
        nd  = int'($urandom_range(1, N));
        mag = int'($urandom_range(0, 10 ** nd - 1));
        return pack(1'b0, 1'($urandom_range(0, 1)), mag, int'($urandom_range(0, ExpMaxVal)));
    endfunction

    // Present operands (called just after a rising edge), wait for the handshake,
    // then scramble the inputs for the duration of the operation.
    task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        op_i       = op;
        a_i        = a;
        b_i        = b;
        in_valid_i = 1'b1;
        ok         = 1'b0;
        for (int c = 0; c < MaxWait; c++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b1;
        a_i        = W'($urandom);
        b_i        = W'($urandom);
        op_i       = 1'($urandom);
    endtask

    // Count cycles after the handshake edge until out_valid_o is seen.
    task automatic wait_result(output logic [W-1:0] y, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        y   = '0;
        for (int c = 1; c <= MaxWait; c++) begin
            @(negedge clk_i);
            if (out_valid_o) begin
                ok  = 1'b1;
                lat = c;
                y   = y_o;
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    // Accept the result on the next rising edge.
    task automatic consume();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    // Reset from power-up: idle, ready, no valid result, cleared output.
    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_o);
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid_o);
        end
        checks++;
        if (y_o !== '0) begin
            errors++; $display("[TB] FAIL reset_y: got %h expected 0", y_o);
        end
        @(posedge clk_i); #1;
    endtask

    // Fixed vectors with hand-derived results and latencies.
    task automatic test_directed();
        logic [W-1:0] ta[8], tb[8], ty[8], y;
        logic         top[8];
        int           tlat[8];
        string        tname[8];
        int           lat;
        bit           ok;
        tname[0] = "add";         top[0] = 0; ta[0] = pack(0, 0, 1234, 0); tb[0] = pack(0, 0, 5, 0);
        ty[0] = pack(0, 0, 1239, 0); tlat[0] = 8;
        tname[1] = "carry";       top[1] = 0; ta[1] = pack(0, 0, 9999, 0); tb[1] = pack(0, 0, 1, 0);
        ty[1] = pack(0, 0, 1000, 1); tlat[1] = 8;
        tname[2] = "overflow";    top[2] = 0; ta[2] = pack(0, 0, 9999, 7); tb[2] = pack(0, 0, 1, 7);
        ty[2] = pack(1, 0, 0, 0);    tlat[2] = -1;
        tname[3] = "sub_swap";    top[3] = 1; ta[3] = pack(0, 0, 12, 0);   tb[3] = pack(0, 0, 345, 0);
        ty[3] = pack(0, 1, 333, 0);  tlat[3] = 8;
        tname[4] = "sub_zero";    top[4] = 1; ta[4] = pack(0, 0, 345, 0);  tb[4] = pack(0, 0, 345, 0);
        ty[4] = pack(0, 0, 0, 0);    tlat[4] = 8;
        tname[5] = "align_norm";  top[5] = 0; ta[5] = pack(0, 0, 500, 1);  tb[5] = pack(0, 0, 25, 0);
        ty[5] = pack(0, 0, 5020, 0); tlat[5] = 10;
        tname[6] = "err_flag";    top[6] = 0; ta[6] = pack(1, 0, 1234, 0); tb[6] = pack(0, 0, 5, 0);
        ty[6] = pack(1, 0, 0, 0);    tlat[6] = 1;
        tname[7] = "err_digit";   top[7] = 0; ta[7] = pack(0, 0, 1234, 0); tb[7] = pack(0, 0, 5, 0);
        tb[7][EW+4 +: 4] = 4'hA;
        ty[7] = pack(1, 0, 0, 0);    tlat[7] = 1;
        for (int i = 0; i < 8; i++) begin
            start_op(top[i], ta[i], tb[i], ok);
            wait_result(y, lat, ok);
            checks++;
            if (!ok) begin
                errors++; $display("[TB] FAIL %s_timeout: no out_valid within %0d cycles", tname[i], MaxWait);
            end
            checks++;
            if (y !== ty[i]) begin
                errors++; $display("[TB] FAIL %s_y: got %h expected %h", tname[i], y, ty[i]);
            end
            if (tlat[i] >= 0) begin
                checks++;
                if (lat != tlat[i]) begin
                    errors++; $display("[TB] FAIL %s_latency: got %0d expected %0d", tname[i], lat, tlat[i]);
                end
            end
            consume();
        end
    endtask

    // Next operation presented during the result handshake starts one cycle later.
    task automatic test_back_to_back();
        logic [W-1:0] a2, b2, y, yexp;
        logic         op2;
        int           lat, latexp;
        bit           ok;
        start_op(1'b0, pack(0, 0, 1234, 0), pack(0, 1, 234, 0), ok);
        wait_result(y, lat, ok);
        checks++;
        if (y !== pack(0, 0, 1000, 0)) begin
            errors++; $display("[TB] FAIL b2b_first_y: got %h expected %h", y, pack(0, 0, 1000, 0));
        end
        a2  = rand_operand();
        b2  = rand_operand();
        op2 = 1'($urandom);
        ref_model(op2, a2, b2, yexp, latexp);
        op_i        = op2;
        a_i         = a2;
        b_i         = b2;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_gap: got valid=%b ready=%b expected valid=0 ready=1", out_valid_o, in_ready_o);
        end
        @(posedge clk_i); #1;
        a_i = W'($urandom);
        b_i = W'($urandom);
        wait_result(y, lat, ok);
        checks++;
        if (!ok || y !== yexp || lat != latexp) begin
            errors++; $display("[TB] FAIL b2b_second: got y=%h lat=%0d expected y=%h lat=%0d", y, lat, yexp, latexp);
        end
        consume();
    endtask

    // Result must be held steady while the consumer stalls.
    task automatic test_backpressure();
        logic [W-1:0] y, yexp;
        int           lat;
        bit           ok;
        yexp = pack(0, 0, 5432, 2);
        start_op(1'b0, pack(0, 0, 4321, 2), pack(0, 0, 1111, 2), ok);
        wait_result(y, lat, ok);
        checks++;
        if (!ok || y !== yexp) begin
            errors++; $display("[TB] FAIL bp_y: got %h expected %h", y, yexp);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== 1'b1 || y_o !== yexp) begin
                errors++; $display("[TB] FAIL bp_hold%0d: got valid=%b y=%h expected valid=1 y=%h", i, out_valid_o, y_o, yexp);
            end
        end
        consume();
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_release: got valid=%b expected 0", out_valid_o);
        end
        @(posedge clk_i); #1;
    endtask

    // Reset during ADD aborts the operation without a result.
    task automatic test_reset_mid_add();
        logic [W-1:0] y;
        int           lat, spurious;
        bit           ok;
        start_op(1'b0, pack(0, 0, 1, 0), pack(0, 0, 2, 0), ok);
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || y_o !== '0) begin
            errors++; $display("[TB] FAIL midreset_state: got valid=%b ready=%b y=%h expected 0 1 0", out_valid_o, in_ready_o, y_o);
        end
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (out_valid_o) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++; $display("[TB] FAIL midreset_noresult: got %0d valid cycles expected 0", spurious);
        end
        @(posedge clk_i); #1;
        start_op(1'b0, pack(0, 0, 1, 0), pack(0, 0, 2, 0), ok);
        wait_result(y, lat, ok);
        checks++;
        if (!ok || y !== pack(0, 0, 3, 0) || lat != 8) begin
            errors++; $display("[TB] FAIL midreset_recover: got y=%h lat=%0d expected y=%h lat=8", y, lat, pack(0, 0, 3, 0));
        end
        consume();
    endtask

    // Random operations against the decimal reference model.
    task automatic test_random();
        logic [W-1:0] a, b, y, yexp;
        logic         op;
        int           lat, latexp;
        bit           ok;
        for (int i = 0; i < 60; i++) begin
            a  = rand_operand();
            b  = rand_operand();
            op = 1'($urandom);
            if ($urandom_range(0, 2) == 0) b[EW-1:0] = a[EW-1:0];
            if ($urandom_range(0, 14) == 0) a[W-1] = 1'b1;
            if ($urandom_range(0, 14) == 0) b[EW+4*$urandom_range(0, N-1) +: 4] = 4'(10 + $urandom_range(0, 5));
            ref_model(op, a, b, yexp, latexp);
            start_op(op, a, b, ok);
            wait_result(y, lat, ok);
            checks++;
            if (!ok || y !== yexp) begin
                errors++; $display("[TB] FAIL rand%0d_y: a=%h b=%h op=%b got %h expected %h", i, a, b, op, y, yexp);
            end
            checks++;
            if (lat != latexp) begin
                errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, latexp);
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_add();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
